ibex_multdiv_seq: RTL

- Parametrised, handshaked, iterative multiply/divide unit for the EX stage; next generation of the in-stage multdiv.
- Owns its own partial-product/remainder registers; no borrowed ALU adder or external intermediate-value register.
- Width is generic, not fixed at 32.
- Valid/ready on both sides lets the EX stage stall the result. Lockstep setback aborts in-flight work.

---
 rtl/ibex_multdiv_seq_if.sv | 26 ++
 rtl/ibex_multdiv_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_seq_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The master side issues requests and consumes results; the unit is the slave.
interface ibex_multdiv_seq_if #(
  parameter int Width = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       op_i;
  logic [Width-1:0] op_a_i;
  logic [Width-1:0] op_b_i;
  logic             data_ind_timing_i;
  logic             valid_o;
  logic             ready_i;
  logic [Width-1:0] result_o;
  logic             busy_o;

  modport master (
    output valid_i, op_i, op_a_i, op_b_i, data_ind_timing_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, op_a_i, op_b_i, data_ind_timing_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/ibex_multdiv_seq.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// both on operand magnitudes with a final sign correction.
module ibex_multdiv_seq #(
  parameter int Width     = 32,
  parameter bit EarlyExit = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                setback_i,
  ibex_multdiv_seq_if.slave   bus
);

  localparam int CntW = $clog2(Width);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_reg, state_next;
  logic [CntW-1:0]  cnt_reg;
  logic [2:0]       op_reg;
  logic             neg_a_reg, neg_b_reg, div_zero_reg;
  logic [Width-1:0] hi_reg, lo_reg, opd_reg, a_reg, result_reg;

  // Request decode
  logic             is_div_in, sign_a_in, sign_b_in, neg_a_in, neg_b_in;
  logic             b_zero_in, accept, early_exit;
  logic [Width-1:0] a_mag, b_mag;

  always_comb begin
    is_div_in  = bus.op_i[2];
    sign_a_in  = (bus.op_i == 3'd1) || (bus.op_i == 3'd2) ||
                 (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    sign_b_in  = (bus.op_i == 3'd1) || (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    neg_a_in   = sign_a_in & bus.op_a_i[Width-1];
    neg_b_in   = sign_b_in & bus.op_b_i[Width-1];
    // Magnitude of -2^(Width-1) is 2^(Width-1), which still fits unsigned in Width bits.
    a_mag      = neg_a_in ? (~bus.op_a_i + Width'(1)) : bus.op_a_i;
    b_mag      = neg_b_in ? (~bus.op_b_i + Width'(1)) : bus.op_b_i;
    b_zero_in  = (bus.op_b_i == '0);
    accept     = (state_reg == IDLE) && bus.valid_i && !setback_i;
    early_exit = EarlyExit && !bus.data_ind_timing_i && is_div_in && b_zero_in;
  end

  // One iteration step; lo_reg holds multiplier or dividend/quotient, hi_reg the
  // upper product half or partial remainder.
  logic             is_div;
  logic [Width:0]   mul_sum, div_shift;
  logic [Width-1:0] div_sub, hi_step, lo_step;
  logic             div_ge;

  always_comb begin
    is_div    = op_reg[2];
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : '0);
    div_shift = {hi_reg, lo_reg[Width-1]};
    div_ge    = div_shift >= {1'b0, opd_reg};
    div_sub   = div_shift[Width-1:0] - opd_reg;
    if (is_div) begin
      hi_step = div_ge ? div_sub : div_shift[Width-1:0];
      lo_step = {lo_reg[Width-2:0], div_ge};
    end else begin
      hi_step = mul_sum[Width:1];
      lo_step = {mul_sum[0], lo_reg[Width-1:1]};
    end
  end

  // Sign correction and selection, applied to the values produced by the final step.
  logic [2*Width-1:0] prod, prod_s;
  logic [Width-1:0]   quot_s, rem_s, final_res;

  always_comb begin
    prod   = {hi_step, lo_step};
    prod_s = (neg_a_reg ^ neg_b_reg) ? (~prod + (2*Width)'(1)) : prod;
    quot_s = (neg_a_reg ^ neg_b_reg) ? (~lo_step + Width'(1)) : lo_step;
    rem_s  = neg_a_reg ? (~hi_step + Width'(1)) : hi_step;
    if (!is_div) begin
      final_res = (op_reg == 3'd0) ? prod_s[Width-1:0] : prod_s[2*Width-1:Width];
    end else if (div_zero_reg) begin
      final_res = op_reg[1] ? a_reg : '1;
    end else begin
      final_res = op_reg[1] ? rem_s : quot_s;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i || setback_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = early_exit ? DONE : CALC;
      CALC:    if (cnt_reg == '0) state_next = DONE;
      DONE:    if (bus.ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs depend on state only, so valid_i/ready_i never reach an output combinationally
  always_comb begin
    bus.ready_o  = (state_reg == IDLE);
    bus.valid_o  = (state_reg == DONE);
    bus.busy_o   = (state_reg == CALC) || (state_reg == DONE);
    bus.result_o = result_reg;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i || setback_i) begin
      cnt_reg      <= '0;
      op_reg       <= '0;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      opd_reg      <= '0;
      a_reg        <= '0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg       <= bus.op_i;
            neg_a_reg    <= neg_a_in;
            neg_b_reg    <= neg_b_in;
            div_zero_reg <= is_div_in & b_zero_in;
            a_reg        <= bus.op_a_i;
            cnt_reg      <= CntW'(Width - 1);
            hi_reg       <= '0;
            lo_reg       <= a_mag;
            opd_reg      <= b_mag;
            if (early_exit) begin
              result_reg <= bus.op_i[1] ? bus.op_a_i : '1;
            end
          end
        end
        CALC: begin
          hi_reg  <= hi_step;
          lo_reg  <= lo_step;
          cnt_reg <= cnt_reg - CntW'(1);
          if (cnt_reg == '0) begin
            result_reg <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
